// File: rtl/train_step_mac_pkg.sv
// Shared types and constants for the train_step multiply-accumulate pipeline.
package train_step_mac_pkg;

  localparam int MAC_MAX_STAGE = 8;

  // Per-token control that rides alongside the product through the delay stages.
  typedef struct packed {
    logic acc_en;
    logic acc_clr;
  } mac_sb_t;

  function automatic int mac_prod_width(input int a_w, input int b_w);
    return a_w + b_w;
  endfunction

endpackage

// File: rtl/train_step_pipe_reg.sv
// One enable-gated pipeline stage: valid bit (async reset) plus data and sideband.
module train_step_pipe_reg
  import train_step_mac_pkg::*;
#(
  parameter int DATA_W = 26
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              valid_in,
  input  logic [DATA_W-1:0] data_in,
  input  mac_sb_t           sb_in,
  output logic              valid_out,
  output logic [DATA_W-1:0] data_out,
  output mac_sb_t           sb_out
);

  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q, data_d;
  mac_sb_t           sb_q, sb_d;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    sb_d    = sb_q;
    if (en) begin
      valid_d = valid_in;
      data_d  = data_in;
      sb_d    = sb_in;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) valid_q <= 1'b0;
    else     valid_q <= valid_d;
  end

  // Payload needs no reset: it is only observed alongside a set valid bit.
  always_ff @(posedge clk) begin
    data_q <= data_d;
    sb_q   <= sb_d;
  end

  assign valid_out = valid_q;
  assign data_out  = data_q;
  assign sb_out    = sb_q;

endmodule

// File: rtl/train_step_mac_pipe.sv
// Pipelined signed multiplier / accumulator with valid-ready handshake and sticky overflow.
module train_step_mac_pipe
  import train_step_mac_pkg::*;
#(
  parameter int ID         = 1,
  parameter int NUM_STAGE  = 3,
  parameter int din0_WIDTH = 14,
  parameter int din1_WIDTH = 12,
  parameter int dout_WIDTH = 32
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [din0_WIDTH-1:0] din0,
  input  logic [din1_WIDTH-1:0] din1,
  input  logic                  acc_en,
  input  logic                  acc_clr,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [dout_WIDTH-1:0] dout,
  output logic                  ovf
);

  localparam int PW   = mac_prod_width(din0_WIDTH, din1_WIDTH);
  localparam int LAST = NUM_STAGE - 1;

  if (ID < 0 || NUM_STAGE < 1 || NUM_STAGE > MAC_MAX_STAGE) begin : g_bad_stage
    $error("train_step_mac_pipe %0d: NUM_STAGE=%0d outside 1..%0d", ID, NUM_STAGE, MAC_MAX_STAGE);
  end
  if (dout_WIDTH < PW) begin : g_bad_width
    $error("train_step_mac_pipe: dout_WIDTH=%0d narrower than product width %0d", dout_WIDTH, PW);
  end

  logic stall;
  logic out_valid_q, out_valid_d;
  logic ovf_q, ovf_d;
  logic signed [dout_WIDTH-1:0] dout_q, dout_d;
  logic signed [dout_WIDTH-1:0] acc_q, acc_d;

  // Index 0 is the combinational input token; 1..LAST are registered stages.
  logic          stg_valid [NUM_STAGE];
  logic [PW-1:0] stg_data  [NUM_STAGE];
  mac_sb_t       stg_sb    [NUM_STAGE];

  logic signed [PW-1:0] a_ext, b_ext, prod_c;

  assign stall    = out_valid_q && !out_ready;
  assign in_ready = !stall;

  assign a_ext  = PW'($signed(din0));
  assign b_ext  = PW'($signed(din1));
  assign prod_c = a_ext * b_ext;

  assign stg_valid[0] = in_valid && in_ready;
  assign stg_data[0]  = prod_c;
  assign stg_sb[0]    = '{acc_en: acc_en, acc_clr: acc_clr};

  // Stage 1 captures the product; later stages are pure delay and may be retimed.
  for (genvar gi = 1; gi < NUM_STAGE; gi++) begin : g_stage
    train_step_pipe_reg #(
      .DATA_W (PW)
    ) u_stage (
      .clk       (ap_clk),
      .rst       (ap_rst),
      .en        (!stall),
      .valid_in  (stg_valid[gi-1]),
      .data_in   (stg_data[gi-1]),
      .sb_in     (stg_sb[gi-1]),
      .valid_out (stg_valid[gi]),
      .data_out  (stg_data[gi]),
      .sb_out    (stg_sb[gi])
    );
  end

  logic signed [dout_WIDTH-1:0] prod_ext, acc_base, acc_sum;
  logic add_ovf;

  always_comb begin
    prod_ext    = dout_WIDTH'($signed(stg_data[LAST]));
    acc_base    = stg_sb[LAST].acc_clr ? '0 : acc_q;
    acc_sum     = acc_base + prod_ext;
    add_ovf     = (acc_base[dout_WIDTH-1] == prod_ext[dout_WIDTH-1]) &&
                  (acc_sum[dout_WIDTH-1] != acc_base[dout_WIDTH-1]);
    out_valid_d = out_valid_q;
    dout_d      = dout_q;
    acc_d       = acc_q;
    ovf_d       = ovf_q;
    if (!stall) begin
      out_valid_d = stg_valid[LAST];
      if (stg_valid[LAST]) begin
        if (stg_sb[LAST].acc_en) begin
          dout_d = acc_sum;
          acc_d  = acc_sum;
          ovf_d  = (stg_sb[LAST].acc_clr ? 1'b0 : ovf_q) | add_ovf;
        end else begin
          dout_d = prod_ext;
        end
      end
    end
  end

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      out_valid_q <= 1'b0;
      dout_q      <= '0;
      acc_q       <= '0;
      ovf_q       <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      dout_q      <= dout_d;
      acc_q       <= acc_d;
      ovf_q       <= ovf_d;
    end
  end

  assign out_valid = out_valid_q;
  assign dout      = dout_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_train_step_mac_pipe.sv
// Scoreboard bench: accepted tokens are modelled arithmetically and checked in order at the output.
module tb_train_step_mac_pipe;

  localparam int NS = 3;
  localparam int AW = 14;
  localparam int BW = 12;
  localparam int DW = 26;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [AW-1:0] din0 = '0;
  logic [BW-1:0] din1 = '0;
  logic          acc_en = 1'b0;
  logic          acc_clr = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [DW-1:0] dout;
  logic          ovf;

  train_step_mac_pipe #(
    .ID         (7),
    .NUM_STAGE  (NS),
    .din0_WIDTH (AW),
    .din1_WIDTH (BW),
    .dout_WIDTH (DW)
  ) dut (
    .ap_clk    (clk),
    .ap_rst    (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .din0      (din0),
    .din1      (din1),
    .acc_en    (acc_en),
    .acc_clr   (acc_clr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .dout      (dout),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    longint dval;
    bit     ovf;
  } exp_t;

  exp_t   exp_q[$];
  longint m_acc = 0;
  bit     m_ovf = 1'b0;

  function automatic void check(input string name, input longint act, input longint req);
    n_tests++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endfunction

  function automatic longint wrap_dw(input longint s);
    logic [DW-1:0] t;
    t = s[DW-1:0];
    return longint'($signed(t));
  endfunction

  // Reference model: evaluated in acceptance order, which is also output order.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      m_acc = 0;
      m_ovf = 1'b0;
    end else if (in_valid && in_ready) begin
      longint p, s, w;
      exp_t   e;
      p = longint'($signed(din0)) * longint'($signed(din1));
      if (acc_en) begin
        s = (acc_clr ? 64'sd0 : m_acc) + p;
        w = wrap_dw(s);
        m_ovf = (acc_clr ? 1'b0 : m_ovf) | (w != s);
        m_acc = w;
        e.dval = w;
      end else begin
        e.dval = p;
      end
      e.ovf = m_ovf;
      exp_q.push_back(e);
    end
  end

  // Monitor
  always @(negedge clk) begin
    if (!rst) begin
      check("in_ready_vs_stall", in_ready, !(out_valid && !out_ready));
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_output", 1, 0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("dout", longint'($signed(dout)), e.dval);
          check("ovf", ovf, e.ovf);
          $display("[TB] out dout=%0d ovf=%0d exp=%0d/%0d", $signed(dout), ovf, e.dval, e.ovf);
        end
      end
    end
  end

  task automatic send(input logic signed [AW-1:0] a, input logic signed [BW-1:0] b,
                      input bit en, input bit clr);
    bit done;
    done = 1'b0;
    din0 = a; din1 = b; acc_en = en; acc_clr = clr; in_valid = 1'b1;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      done = in_ready;
      @(posedge clk);
      #1;
    end
    if (!done) check("send_timeout", 0, 1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 300 && !done; i++) begin
      @(negedge clk);
      done = (exp_q.size() == 0) && !out_valid;
    end
    if (!done) check("drain_timeout", int'(exp_q.size()), 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_dout", longint'(dout), 0);
    check("rst_ovf", ovf, 0);
    #2 rst = 1'b0;
    @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    @(posedge clk);
    #1;

    // Corner product and latency
    din0 = AW'(-8192); din1 = BW'(-2048); acc_en = 1'b0; acc_clr = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = 0;
    for (int j = 1; j <= 20; j++) begin
      @(negedge clk);
      if (out_valid) begin
        lat = j;
        break;
      end
    end
    check("corner_latency", lat, NS);
    drain();

    // Accumulate chain, then with a plain token interleaved
    send(3, 4, 1, 1); send(-5, 2, 1, 0); send(7, -1, 1, 0);
    drain();
    send(3, 4, 1, 1); send(10, 10, 0, 0); send(-5, 2, 1, 0); send(7, -1, 1, 0);
    drain();

    // Backpressure mid-stream
    fork
      begin
        for (int i = 0; i < 10; i++)
          send(AW'($urandom), BW'($urandom), 1'($urandom_range(0, 1)), (i == 0));
      end
      begin
        repeat (5) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (4) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();

    // Overflow, clear by a later clr token, overflow again
    send(-8192, -2048, 1, 1); send(-8192, -2048, 1, 0);
    send(1, 1, 1, 1);
    send(-8192, -2048, 1, 1); send(-8192, -2048, 1, 0);
    drain();
    check("ovf_before_reset", ovf, 1);

    // Mid-flight reset
    send(1, 2, 1, 0); send(3, 4, 0, 0); send(5, 6, 1, 1);
    rst = 1'b1;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_dout", longint'(dout), 0);
    check("midrst_ovf", ovf, 0);
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    send(-3, 5, 1, 0);
    drain();

    // Randomised traffic with random backpressure
    for (int c = 0; c < 400; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      din0      = AW'($urandom);
      din1      = BW'($urandom);
      acc_en    = 1'($urandom_range(0, 1));
      acc_clr   = ($urandom_range(0, 4) == 0);
      out_ready = ($urandom_range(0, 3) != 0);
      @(posedge clk);
      #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
